// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory block-port arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 28;   // block address = byte address [31:4]
    localparam int BLOCK_W_DEF = 128;  // 4 x 32-bit words per block

    // Requester identifiers, also used as the last-grant encoding
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_priority_select.sv
// Combinational tie-breaker for the two cache requesters.
// Default build: D-cache always beats I-cache.
// With MEM_ARB_ROUND_ROBIN_EN defined: on a tie the requester that was not
// granted most recently wins; single requests are granted as-is.
`timescale 1ns/1ps
module arb_priority_select
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_valid,
    output logic grant_id
);

    // Pick a winner whenever at least one cache is asking
    always_comb begin
        grant_valid = i_req | d_req;
        grant_id    = d_req ? REQ_D : REQ_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one main-memory block port between the I-cache (refill
// reads) and the D-cache (refills and write-backs). Each level request is
// turned into one serialized memory command and a one-cycle acknowledge.
// A DONE cycle after every transfer lets the served cache drop its request
// before the next arbitration. All outputs are registered.
// Optional macro: MEM_ARB_ROUND_ROBIN_EN (alternating tie-break instead of
// fixed D-over-I priority).
`timescale 1ns/1ps
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF
)
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_REQ,
    input  logic [ADDR_W-1:0]  I_ADDR,
    output logic               I_ACK,
    output logic [BLOCK_W-1:0] I_RDATA,
    input  logic               D_REQ,
    input  logic               D_WR,
    input  logic [ADDR_W-1:0]  D_ADDR,
    input  logic [BLOCK_W-1:0] D_WDATA,
    output logic               D_ACK,
    output logic [BLOCK_W-1:0] D_RDATA,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic [BLOCK_W-1:0] MEM_WDATA,
    input  logic [BLOCK_W-1:0] MEM_RDATA,
    input  logic               MEM_ACK
);

    arb_state_t         state_reg;
    logic               i_ack_reg;
    logic               d_ack_reg;
    logic [BLOCK_W-1:0] i_rdata_reg;
    logic [BLOCK_W-1:0] d_rdata_reg;
    logic               mem_read_reg;
    logic               mem_write_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [BLOCK_W-1:0] mem_wdata_reg;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic               last_grant_reg;
`endif

    logic grant_valid;
    logic grant_id;

    arb_priority_select u_select (
        .i_req       (I_REQ),
        .d_req       (D_REQ),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_reg),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Arbitration FSM: grant in IDLE, hold command until MEM_ACK, ack in DONE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            i_ack_reg     <= 1'b0;
            d_ack_reg     <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_reg <= REQ_I;
`endif
        end else begin
            // Acknowledges are single-cycle pulses
            i_ack_reg <= 1'b0;
            d_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        if (grant_id == REQ_D) begin
                            state_reg     <= GNT_D;
                            mem_addr_reg  <= D_ADDR;
                            mem_wdata_reg <= D_WDATA;
                            mem_write_reg <= D_WR;
                            mem_read_reg  <= ~D_WR;
                        end else begin
                            state_reg     <= GNT_I;
                            mem_addr_reg  <= I_ADDR;
                            mem_read_reg  <= 1'b1;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_reg <= grant_id;
`endif
                    end
                end
                GNT_I: begin
                    if (MEM_ACK) begin
                        mem_read_reg <= 1'b0;
                        i_rdata_reg  <= MEM_RDATA;
                        i_ack_reg    <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                GNT_D: begin
                    if (MEM_ACK) begin
                        // Write-backs leave the refill buffer untouched
                        if (mem_read_reg) begin
                            d_rdata_reg <= MEM_RDATA;
                        end
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        d_ack_reg     <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign I_ACK     = i_ack_reg;
    assign I_RDATA   = i_rdata_reg;
    assign D_ACK     = d_ack_reg;
    assign D_RDATA   = d_rdata_reg;
    assign MEM_READ  = mem_read_reg;
    assign MEM_WRITE = mem_write_reg;
    assign MEM_ADDR  = mem_addr_reg;
    assign MEM_WDATA = mem_wdata_reg;

endmodule
